apb_target_mux_timeout: RTL and testbench
=========================================

// Module: apb_target_mux_timeout
// PURPOSE
//  APB fabric stage: one APB master port fans out to NUM_TARGETS APB targets, decoded on paddr[SEL_MSB:SEL_LSB].
//  Generalises the single-target paddr[31:28]==0 decode used in rv_timer benches: N targets, registered select.
//  Adds an error response for unmapped addresses and a per-access timeout that aborts hung targets.
//  Sits between a CPU/debug APB master and peripherals (timer, gpio, uart, ...).
// PARAMETERS
//  NUM_TARGETS     4    targets, 1..16; target i owns select value i, values >= NUM_TARGETS are unmapped
//  SEL_MSB         31   top bit of select field in paddr
//  SEL_LSB         28   bottom bit of select field; SEL_MSB-SEL_LSB <= 3
//  TIMEOUT_CYCLES  256  access-phase cycles allowed before abort, 2..65535; 0 disables the timeout
// PORTS
//  clk                        in   1         clock
//  reset_n                    in   1         asynchronous active-low reset
//  apb_request__paddr/penable/psel/pwrite/pwdata  in  32/1/1/1/32  upstream request
//  apb_response__prdata/pready/perr               out 32/1/1       upstream response
//  tgt_apb_request__paddr/penable/pwrite/pwdata   out 32/1/1/32    shared downstream request fields
//  tgt_apb_request__psel      out  NUM_TARGETS     one-hot psel, bit i to target i
//  tgt_apb_response__prdata   in   32*NUM_TARGETS  target i at bits [32i+31:32i]
//  tgt_apb_response__pready   in   NUM_TARGETS     per-target pready
//  tgt_apb_response__perr     in   NUM_TARGETS     per-target perr
//  timeout_event              out  1   one-cycle pulse when a timeout abort is issued
//  timeout_sticky             out  1   set on timeout, held until status_clear
//  timeout_target             out  4   index of target that last timed out
//  status_clear               in   1   clears timeout_sticky
// BEHAVIOUR
//  FSM: IDLE, ACCESS, ABORTED. Reset (async, any time incl. mid-access): IDLE, all outputs 0, counter 0, sticky 0.
//  IDLE: setup phase (psel=1, penable=0) decodes the select field. Decoded index and unmapped flag are latched; go to ACCESS.
//   Mapped in setup: tgt psel[idx]=1 combinationally in the same cycle.
//  ACCESS, mapped: tgt psel[idx]=1. Response = target idx prdata/pready/perr.
//   Completion (penable & pready): next state IDLE, counter 0; back-to-back setup accepted the following cycle.
//  ACCESS, unmapped: no tgt psel. Response pready=1, perr=1, prdata=0 in the first penable cycle (zero wait states).
//  Timeout: counter increments every ACCESS cycle with penable=1 and pready_tgt=0.
//   Counter == TIMEOUT_CYCLES-1 with no pready: abort. Upstream sees pready=1, perr=1, prdata=0 that cycle.
//   In the abort cycle: timeout_event=1, timeout_sticky set, timeout_target=idx, tgt psel=0.
//   Next state is ABORTED.
//  ABORTED: tgt psel=0. Wait for upstream psel=0 or a new setup. A new setup is handled as IDLE.
//   A late pready from the aborted target is ignored.
//  Target pready in the abort cycle: the target wins, normal response, no timeout.
//  Upstream drops psel mid-ACCESS (protocol error): go to IDLE, no response, counter cleared, no timeout.
//  status_clear and a timeout set in the same cycle: set wins. timeout_target updates only on a new timeout.
//  Outside an access phase: apb_response pready=0, perr=0, prdata=0. tgt paddr/penable/pwrite/pwdata pass through.
//  Counter is 16 bits and cannot wrap (bounded by TIMEOUT_CYCLES). TIMEOUT_CYCLES=0: the counter is held at 0.
// TESTING
//  Write paddr=0x1000_0004 with target 1 pready=1 immediately
//   -> tgt psel=4'b0010 for 2 cycles, upstream pready on cycle 2, perr=0.
//  Read paddr=0x2000_0000, target 2 pready after 3 wait states, prdata=0xDEADBEEF
//   -> upstream prdata=0xDEADBEEF, pready on the 4th access cycle.
//  Access paddr=0x7000_0000 (NUM_TARGETS=4)
//   -> no tgt psel, pready=1 and perr=1 on the first penable cycle, prdata=0.
//  Target 3 never readies, TIMEOUT_CYCLES=8
//   -> perr=1 on access cycle 8, timeout_event pulse, sticky=1, timeout_target=3, tgt psel[3]=0 next cycle.
//  status_clear asserted in the same cycle as a second timeout on target 0 -> sticky stays 1, timeout_target=0.
//  reset_n low in the middle of an access at wait cycle 5 -> all outputs 0 immediately; the next access starts from IDLE.

Source files
------------

// File: rtl/apb_target_mux_timeout.sv
// APB fabric stage: one upstream master fanned out to NUM_TARGETS targets decoded on a paddr field,
// with an error response for unmapped addresses and an access-phase timeout that aborts hung targets.
module apb_target_mux_timeout #(
  parameter int NUM_TARGETS    = 4,
  parameter int SEL_MSB        = 31,
  parameter int SEL_LSB        = 28,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                apb_request__paddr,
  input  logic                       apb_request__penable,
  input  logic                       apb_request__psel,
  input  logic                       apb_request__pwrite,
  input  logic [31:0]                apb_request__pwdata,
  output logic [31:0]                apb_response__prdata,
  output logic                       apb_response__pready,
  output logic                       apb_response__perr,
  output logic [31:0]                tgt_apb_request__paddr,
  output logic                       tgt_apb_request__penable,
  output logic                       tgt_apb_request__pwrite,
  output logic [31:0]                tgt_apb_request__pwdata,
  output logic [NUM_TARGETS-1:0]     tgt_apb_request__psel,
  input  logic [32*NUM_TARGETS-1:0]  tgt_apb_response__prdata,
  input  logic [NUM_TARGETS-1:0]     tgt_apb_response__pready,
  input  logic [NUM_TARGETS-1:0]     tgt_apb_response__perr,
  output logic                       timeout_event,
  output logic                       timeout_sticky,
  output logic [3:0]                 timeout_target,
  input  logic                       status_clear
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ABORTED
  } state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        unmapped_q, unmapped_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sticky_q;
  logic [3:0]  tgt_q;

  logic        setup;
  logic [3:0]  sel_field;
  logic        sel_mapped;
  logic [3:0]  psel_idx;
  logic        psel_en;
  logic        abort;

  logic [NUM_TARGETS-1:0] hit;
  logic [NUM_TARGETS-1:0] rd_col [32];
  logic [31:0]            sel_prdata;
  logic                   sel_pready;
  logic                   sel_perr;

  assign setup      = apb_request__psel & ~apb_request__penable;
  assign sel_field  = 4'(apb_request__paddr[SEL_MSB:SEL_LSB]);
  assign sel_mapped = ({1'b0, sel_field} < 5'(NUM_TARGETS));

  // Response mux on the registered index, built as a one-hot AND-OR per data bit.
  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_hit
    assign hit[g]                   = (idx_q == 4'(g));
    assign tgt_apb_request__psel[g] = psel_en & (psel_idx == 4'(g));
  end

  for (genvar b = 0; b < 32; b++) begin : g_rd_bit
    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_rd_tgt
      assign rd_col[b][g] = tgt_apb_response__prdata[32*g + b];
    end
    assign sel_prdata[b] = |(rd_col[b] & hit);
  end

  assign sel_pready = |(hit & tgt_apb_response__pready);
  assign sel_perr   = |(hit & tgt_apb_response__perr);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d              = state_q;
    idx_d                = idx_q;
    unmapped_d           = unmapped_q;
    cnt_d                = cnt_q;
    psel_idx             = idx_q;
    psel_en              = 1'b0;
    abort                = 1'b0;
    apb_response__prdata = '0;
    apb_response__pready = 1'b0;
    apb_response__perr   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ABORTED: begin
        if (setup) begin
          // Decode is visible to the target in the setup cycle itself, then held in idx_q.
          idx_d      = sel_field;
          unmapped_d = ~sel_mapped;
          cnt_d      = '0;
          psel_idx   = sel_field;
          psel_en    = sel_mapped;
          state_d    = ST_ACCESS;
        end else if (!apb_request__psel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (!apb_request__psel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (unmapped_q) begin
          if (apb_request__penable) begin
            apb_response__pready = 1'b1;
            apb_response__perr   = 1'b1;
            state_d              = ST_IDLE;
          end
        end else begin
          psel_en = 1'b1;
          if (apb_request__penable) begin
            apb_response__prdata = sel_prdata;
            apb_response__pready = sel_pready;
            apb_response__perr   = sel_perr & sel_pready;
            if (sel_pready) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LAST) begin
              // A ready target in this same cycle takes the branch above instead.
              abort                = 1'b1;
              psel_en              = 1'b0;
              apb_response__prdata = '0;
              apb_response__pready = 1'b1;
              apb_response__perr   = 1'b1;
              cnt_d                = '0;
              state_d              = ST_ABORTED;
            end else if (TIMEOUT_EN) begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      unmapped_q <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      tgt_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      unmapped_q <= unmapped_d;
      cnt_q      <= cnt_d;
      if (abort) begin
        sticky_q <= 1'b1;
        tgt_q    <= idx_q;
      end else if (status_clear) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign timeout_event            = abort;
  assign timeout_sticky           = sticky_q;
  assign timeout_target           = tgt_q;
  assign tgt_apb_request__paddr   = apb_request__paddr;
  assign tgt_apb_request__penable = apb_request__penable;
  assign tgt_apb_request__pwrite  = apb_request__pwrite;
  assign tgt_apb_request__pwdata  = apb_request__pwdata;

endmodule

// File: tb/tb_apb_target_mux_timeout.sv
// Self-checking bench for apb_target_mux_timeout: directed vector table, hand-written multi-cycle
// corner cases, and randomized accesses checked against a transaction-level model.
module tb_apb_target_mux_timeout;

  localparam int NT   = 4;
  localparam int TO   = 8;
  localparam int HANG = 1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   paddr, pwdata;
  logic          penable, psel, pwrite;
  logic [31:0]   prdata;
  logic          pready, perr;
  logic [31:0]   t_paddr, t_pwdata;
  logic          t_penable, t_pwrite;
  logic [NT-1:0] t_psel;
  logic [31:0]   t_rd [NT];
  logic [32*NT-1:0] t_rd_flat;
  logic [NT-1:0] t_pready, t_perr;
  logic          ev, sticky, status_clear;
  logic [3:0]    ttgt;

  for (genvar g = 0; g < NT; g++) begin : g_pack
    assign t_rd_flat[32*g +: 32] = t_rd[g];
  end

  always #5 clk = ~clk;

  apb_target_mux_timeout #(
    .NUM_TARGETS(NT), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .apb_request__paddr(paddr), .apb_request__penable(penable), .apb_request__psel(psel),
    .apb_request__pwrite(pwrite), .apb_request__pwdata(pwdata),
    .apb_response__prdata(prdata), .apb_response__pready(pready), .apb_response__perr(perr),
    .tgt_apb_request__paddr(t_paddr), .tgt_apb_request__penable(t_penable),
    .tgt_apb_request__pwrite(t_pwrite), .tgt_apb_request__pwdata(t_pwdata),
    .tgt_apb_request__psel(t_psel),
    .tgt_apb_response__prdata(t_rd_flat), .tgt_apb_response__pready(t_pready),
    .tgt_apb_response__perr(t_perr),
    .timeout_event(ev), .timeout_sticky(sticky), .timeout_target(ttgt),
    .status_clear(status_clear)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         sticky_m;
  logic [3:0] tt_m;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    int          wait_c;
    bit          terr;
    logic [31:0] rdata;
    bit          gap;
    int          exp_lat;
    bit          exp_perr;
    logic [31:0] exp_prdata;
    bit          exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Randomise every target response except the one being modelled.
  task automatic noise(input int keep);
    for (int i = 0; i < NT; i++) begin
      if (i != keep) begin
        t_pready[2'(i)] = 1'($urandom);
        t_perr[2'(i)]   = 1'($urandom);
        t_rd[2'(i)]     = $urandom;
      end
    end
  endtask

  // Transaction-level reference: latency in access cycles, error flag, read data, timeout.
  function automatic void model(input logic [3:0] sel, input int w, input bit terr,
                                input logic [31:0] rdata, output int lat, output bit e_perr,
                                output logic [31:0] e_prdata, output bit to);
    if (sel >= 4'(NT)) begin
      lat = 1; e_perr = 1'b1; e_prdata = '0; to = 1'b0;
    end else if (w < TO) begin
      lat = w + 1; e_perr = terr; e_prdata = rdata; to = 1'b0;
    end else begin
      lat = TO; e_perr = 1'b1; e_prdata = '0; to = 1'b1;
    end
  endfunction

  // Entered and left just after a rising edge. clear_cycle: -1 none, 0 setup, k access cycle k.
  task automatic run_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                            input int w, input bit terr, input logic [31:0] rdata,
                            input int clear_cycle, input bit gap, input int exp_lat,
                            input bit exp_perr, input logic [31:0] exp_prdata, input bit exp_to);
    logic [3:0]    sel;
    logic [1:0]    ti;
    bit            mapped;
    logic [NT-1:0] onehot, exp_psel;
    int            obs_lat, events;
    logic          obs_perr;
    logic [31:0]   obs_prdata;
    sel      = addr[31:28];
    ti       = sel[1:0];
    mapped   = (sel < 4'(NT));
    onehot   = mapped ? (4'b0001 << ti) : 4'b0000;
    obs_lat  = 0;
    events   = 0;
    obs_perr = 1'b0;
    obs_prdata = '0;

    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    status_clear = (clear_cycle == 0);
    noise(-1);
    @(negedge clk);
    check("setup_tgt_psel", 32'(t_psel), 32'(onehot));
    check("setup_pready", 32'(pready), 32'd0);
    check("pass_paddr", t_paddr, addr);
    check("pass_pwdata", t_pwdata, wdata);
    check("pass_pwrite", 32'(t_pwrite), 32'(wr));
    check("sticky", 32'(sticky), 32'(sticky_m));
    check("timeout_target", 32'(ttgt), 32'(tt_m));
    events += int'(ev);

    for (int k = 1; k <= 20 && obs_lat == 0; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      status_clear = (clear_cycle == k);
      noise(mapped ? int'(ti) : -1);
      if (mapped) begin
        t_pready[ti] = (k > w);
        t_perr[ti]   = terr;
        t_rd[ti]     = rdata;
      end
      @(negedge clk);
      events += int'(ev);
      exp_psel = (exp_to && k == exp_lat) ? 4'b0000 : onehot;
      if (k <= exp_lat) check("access_tgt_psel", 32'(t_psel), 32'(exp_psel));
      if (pready) begin
        obs_lat = k; obs_perr = perr; obs_prdata = prdata;
      end
    end
    check("latency", 32'(obs_lat), 32'(exp_lat));
    check("perr", 32'(obs_perr), 32'(exp_perr));
    check("prdata", obs_prdata, exp_prdata);

    @(posedge clk); #1;
    if (gap || obs_lat == 0) begin
      psel = 1'b0; penable = 1'b0; status_clear = 1'b0;
      noise(-1);
      if (mapped) t_pready[ti] = 1'b1;
      @(negedge clk);
      events += int'(ev);
      check("idle_pready", 32'(pready), 32'd0);
      check("idle_tgt_psel", 32'(t_psel), 32'd0);
      @(posedge clk); #1;
    end
    check("timeout_events", 32'(events), 32'(exp_to));

    if (exp_to) begin
      sticky_m = 1'b1;
      tt_m     = sel;
    end else if (clear_cycle >= 0) begin
      sticky_m = 1'b0;
    end
  endtask

  vec_t vecs [8];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    int          lat;
    bit          e_perr, e_to;
    logic [31:0] e_rd, addr, rd;
    logic [3:0]  sel;
    int          w, clr;
    bit          terr;

    vecs[0] = '{32'h1000_0004, 1, 32'hA5A5_0001, 0,    0, 32'h0000_1111, 0, 1, 0, 32'h0000_1111, 0};
    vecs[1] = '{32'h2000_0000, 0, 32'h0,         3,    0, 32'hDEAD_BEEF, 1, 4, 0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{32'h7000_0000, 0, 32'h0,         0,    0, 32'h0,         1, 1, 1, 32'h0,         0};
    vecs[3] = '{32'h0000_0010, 0, 32'h0,         2,    1, 32'h0000_CAFE, 1, 3, 1, 32'h0000_CAFE, 0};
    vecs[4] = '{32'h3000_0000, 0, 32'h0,         7,    0, 32'h1234_5678, 1, 8, 0, 32'h1234_5678, 0};
    vecs[5] = '{32'h3000_0100, 0, 32'h0,         HANG, 0, 32'h5555_5555, 0, 8, 1, 32'h0,         1};
    vecs[6] = '{32'hF000_0000, 1, 32'h0BAD_F00D, 0,    0, 32'h0,         1, 1, 1, 32'h0,         0};
    vecs[7] = '{32'h4000_0000, 0, 32'h0,         0,    0, 32'h0,         1, 1, 1, 32'h0,         0};

    reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; status_clear = 1'b0;
    noise(-1);
    sticky_m = 1'b0; tt_m = '0;
    #12;
    check("rst_tgt_psel", 32'(t_psel), 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_target", 32'(ttgt), 32'd0);
    check("rst_event", 32'(ev), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_access(v.addr, v.wr, v.wdata, v.wait_c, v.terr, v.rdata, -1, v.gap,
                 v.exp_lat, v.exp_perr, v.exp_prdata, v.exp_to);
    end

    // Second timeout, on target 0, with status_clear in the abort cycle: the set wins.
    run_access(32'h0000_0040, 0, 32'h0, HANG, 0, 32'h0, TO, 1, TO, 1, 32'h0, 1);
    // status_clear alone during a normal access clears the sticky flag.
    run_access(32'h1000_0000, 0, 32'h0, 1, 0, 32'h0000_2222, 1, 1, 2, 0, 32'h0000_2222, 0);

    // Upstream drops psel mid-access: no response, no timeout, counter restarts.
    status_clear = 1'b0; psel = 1'b1; penable = 1'b0; paddr = 32'h2000_0000; pwrite = 1'b0;
    noise(-1); t_pready[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      penable = 1'b1; noise(2); t_pready[2] = 1'b0;
      @(negedge clk);
      check("drop_wait_pready", 32'(pready), 32'd0);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; noise(-1);
    @(negedge clk);
    check("drop_tgt_psel", 32'(t_psel), 32'd0);
    check("drop_pready", 32'(pready), 32'd0);
    check("drop_event", 32'(ev), 32'd0);
    @(posedge clk); #1;
    run_access(32'h2000_0000, 0, 32'h0, HANG, 0, 32'h0, -1, 1, TO, 1, 32'h0, 1);

    // Reset in the middle of an access at wait cycle 5.
    psel = 1'b1; penable = 1'b0; paddr = 32'h1000_0000; pwrite = 1'b0;
    noise(-1); t_pready[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      penable = 1'b1; noise(1); t_pready[1] = 1'b0;
    end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_tgt_psel", 32'(t_psel), 32'd0);
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_perr", 32'(perr), 32'd0);
    check("midrst_prdata", prdata, 32'd0);
    check("midrst_event", 32'(ev), 32'd0);
    check("midrst_sticky", 32'(sticky), 32'd0);
    check("midrst_target", 32'(ttgt), 32'd0);
    sticky_m = 1'b0; tt_m = '0;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_access(32'h1000_0000, 0, 32'h0, 2, 0, 32'h0000_3333, -1, 1, 3, 0, 32'h0000_3333, 0);

    for (int n = 0; n < 40; n++) begin
      sel  = 4'($urandom_range(0, 5));
      addr = {sel, 28'($urandom)};
      w    = ($urandom_range(0, 5) == 0) ? HANG : int'($urandom_range(0, 9));
      terr = 1'($urandom);
      rd   = $urandom;
      model(sel, w, terr, rd, lat, e_perr, e_rd, e_to);
      clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
      run_access(addr, 1'($urandom), $urandom, w, terr, rd, clr, 1'($urandom),
                 lat, e_perr, e_rd, e_to);
    end

    psel = 1'b0; penable = 1'b0; status_clear = 1'b0;
    @(negedge clk);
    check("final_sticky", 32'(sticky), 32'(sticky_m));
    check("final_target", 32'(ttgt), 32'(tt_m));
    check("final_pready", 32'(pready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
